// File: rtl/rom_pic_pkg.sv
// rom_pic_pkg: shared constants, sync bundle type and luma helper for the picture ROM reader
package rom_pic_pkg;
    localparam logic [23:0] BG_COLOR_DEF = 24'h000000;
    localparam logic [7:0] LUMA_R = 8'd77;
    localparam logic [7:0] LUMA_G = 8'd150;
    localparam logic [7:0] LUMA_B = 8'd29;
    localparam int R_HI = 23;
    localparam int R_LO = 16;
    localparam int G_HI = 15;
    localparam int G_LO = 8;
    localparam int B_HI = 7;
    localparam int B_LO = 0;
    typedef struct packed {
        logic vs;
        logic hs;
        logic de;
    } sync_t;
    function automatic logic [17:0] luma_sum(input logic [23:0] c);
        return 18'(LUMA_R) * 18'(c[R_HI:R_LO]) + 18'(LUMA_G) * 18'(c[G_HI:G_LO]) + 18'(LUMA_B) * 18'(c[B_HI:B_LO]);
    endfunction
endpackage

// File: rtl/rom_pic_reader_rgb2gray.sv
// rgb2gray: registered RGB888 -> 8-bit luma, 1 clk latency, truncating (no rounding)
// ports: clk, rst_n (async active-low), rgb in [23:0], gray out [7:0]
module rgb2gray import rom_pic_pkg::*; (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] rgb,
    output logic [7:0]  gray
);
    logic [17:0] sum;
    always_comb sum = luma_sum(rgb);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            gray <= '0;
        else
            gray <= 8'(sum >> 8);
    end
endmodule

// File: rtl/rom_pic_reader.sv
// rom_pic_reader: scans the picture ROM into a window of the video frame, 3 clk latency
// ports: clk, rst_n (async active-low), vs_in/hs_in/de_in timing in,
//        rom_addr (registered) / rom_rd_data (1 clk read latency),
//        vs_out/hs_out/de_out delayed syncs, rgb_out pixel, gray_out luma
module rom_pic_reader import rom_pic_pkg::*; #(
    parameter int          H_ACT    = 1920,
    parameter int          V_ACT    = 1080,
    parameter int          IMG_W    = 256,
    parameter int          IMG_H    = 256,
    parameter int          WIN_X    = 832,
    parameter int          WIN_Y    = 412,
    parameter int          ADDR_W   = 16,
    parameter int          DATA_W   = 24,
    parameter logic [23:0] BG_COLOR = BG_COLOR_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vs_in,
    input  logic              hs_in,
    input  logic              de_in,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rd_data,
    output logic              vs_out,
    output logic              hs_out,
    output logic              de_out,
    output logic [23:0]       rgb_out,
    output logic [7:0]        gray_out
);
    localparam logic [11:0] X_LO = 12'(WIN_X);
    localparam logic [11:0] X_HI = 12'(WIN_X + IMG_W);
    localparam logic [11:0] X_ACT = 12'(H_ACT);
    localparam logic [10:0] Y_LO = 11'(WIN_Y);
    localparam logic [10:0] Y_HI = 11'(WIN_Y + IMG_H);
    localparam logic [10:0] Y_ACT = 11'(V_ACT);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

    if (longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_W)) begin : g_addr_chk
        $error("rom_pic_reader: IMG_W*IMG_H does not fit in ADDR_W");
    end
    if (DATA_W != 24) begin : g_data_chk
        $error("rom_pic_reader: DATA_W must be 24");
    end

    logic              vs_d;
    logic              de_d;
    logic              frame_ok;
    logic [11:0]       x_cnt;
    logic [10:0]       y_cnt;
    logic [ADDR_W-1:0] row_base;
    logic              win_d1;
    logic              win_d2;
    sync_t             sync_d1;
    sync_t             sync_d2;
    logic              vs_rise;
    logic              de_fall;
    logic              y_img;
    logic              in_win;
    logic [23:0]       sel;

    always_comb begin
        vs_rise = vs_in & ~vs_d;
        de_fall = de_d & ~de_in;
        y_img = y_cnt >= Y_LO && y_cnt < Y_HI;
        in_win = frame_ok && de_in && x_cnt >= X_LO && x_cnt < X_HI && x_cnt < X_ACT && y_img && y_cnt < Y_ACT;
        sel = win_d2 ? rom_rd_data : BG_COLOR;
    end

    // vs clear takes priority over the de-fall increment for y_cnt and row_base
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d <= 1'b0;
            de_d <= 1'b0;
            frame_ok <= 1'b0;
            x_cnt <= '0;
            y_cnt <= '0;
            row_base <= '0;
            rom_addr <= '0;
            win_d1 <= 1'b0;
            win_d2 <= 1'b0;
            sync_d1 <= '0;
            sync_d2 <= '0;
            vs_out <= 1'b0;
            hs_out <= 1'b0;
            de_out <= 1'b0;
            rgb_out <= '0;
        end else begin
            vs_d <= vs_in;
            de_d <= de_in;
            frame_ok <= frame_ok | vs_rise;
            x_cnt <= !de_in ? '0 : &x_cnt ? x_cnt : x_cnt + 12'd1;
            y_cnt <= vs_rise ? '0 : !de_fall || &y_cnt ? y_cnt : y_cnt + 11'd1;
            row_base <= vs_rise ? '0 : de_fall && y_img ? row_base + ROW_STEP : row_base;
            rom_addr <= in_win ? row_base + ADDR_W'(x_cnt - X_LO) : rom_addr;
            win_d1 <= in_win;
            win_d2 <= win_d1;
            sync_d1 <= {vs_in, hs_in, de_in};
            sync_d2 <= sync_d1;
            {vs_out, hs_out, de_out} <= sync_d2;
            rgb_out <= sel;
        end
    end

    // luma register sits in parallel with rgb_out, both fed by the stage-3 select
    rgb2gray u_gray (
        .clk   (clk),
        .rst_n (rst_n),
        .rgb   (sel),
        .gray  (gray_out)
    );
endmodule

// File: tb/tb_rom_pic_reader.sv
// tb_rom_pic_reader: geometry-based reference model, random ROM/reset, luma vector table
module tb_rom_pic_reader;
    localparam int HA = 16, VA = 8, IW = 4, IH = 4, WY = 2, WXA = 6, WXB = 14;
    localparam int HT = 24, VT = 11;

    typedef struct packed {
        logic        vs;
        logic        hs;
        logic        de;
        logic [23:0] rgb;
        logic [7:0]  gray;
    } exp_t;
    typedef struct packed {
        logic [23:0] rgb;
        logic [7:0]  gray;
    } luma_vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
    logic [7:0] addr0, addr1;
    logic [23:0] rd0 = '0, rd1 = '0, rgb0, rgb1, g_in = '0;
    logic vs0, hs0, de0, vs1, hs1, de1;
    logic [7:0] gray0, gray1, g_out;
    logic [23:0] rnd_mem [256];
    int mode = 0;
    int h = 0, v = 0;
    bit novs = 0, early = 0, mok = 0, pvs = 0;
    int checks = 0, errors = 0;
    exp_t q0[$], q1[$];

    always #5 clk = ~clk;

    rom_pic_reader #(.H_ACT(HA), .V_ACT(VA), .IMG_W(IW), .IMG_H(IH), .WIN_X(WXA), .WIN_Y(WY), .ADDR_W(8), .DATA_W(24)) u_dut (
        .clk(clk), .rst_n(rst_n), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
        .rom_addr(addr0), .rom_rd_data(rd0),
        .vs_out(vs0), .hs_out(hs0), .de_out(de0), .rgb_out(rgb0), .gray_out(gray0)
    );
    rom_pic_reader #(.H_ACT(HA), .V_ACT(VA), .IMG_W(IW), .IMG_H(IH), .WIN_X(WXB), .WIN_Y(WY), .ADDR_W(8), .DATA_W(24)) u_clip (
        .clk(clk), .rst_n(rst_n), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
        .rom_addr(addr1), .rom_rd_data(rd1),
        .vs_out(vs1), .hs_out(hs1), .de_out(de1), .rgb_out(rgb1), .gray_out(gray1)
    );
    rgb2gray u_luma (.clk(clk), .rst_n(rst_n), .rgb(g_in), .gray(g_out));

    function automatic logic [23:0] rom_f(int m, logic [7:0] a);
        return m == 0 ? {a, a, a} : m == 1 ? 24'hFFFFFF : m == 2 ? 24'hFF0000 : rnd_mem[a];
    endfunction

    always @(posedge clk) begin
        rd0 <= rom_f(mode, addr0);
        rd1 <= rom_f(mode, addr1);
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s t=%0t got %h want %h", n, $time, a, x);
        end
    endtask

    // expected output for the pixel currently driven, from frame geometry
    function automatic exp_t model(int wx);
        exp_t e;
        bit inw;
        logic [23:0] c;
        inw = mok && de_in && h >= wx && h < wx + IW && h < HA && v >= WY && v < WY + IH && v < VA;
        c = inw ? rom_f(mode, 8'((v - WY) * IW + (h - wx))) : 24'h0;
        e.vs = vs_in;
        e.hs = hs_in;
        e.de = de_in;
        e.rgb = c;
        e.gray = 8'((77 * c[23:16] + 150 * c[15:8] + 29 * c[7:0]) >> 8);
        return e;
    endfunction

    task automatic step(input logic rn);
        exp_t e;
        if (q0.size() == 3) begin
            e = q0.pop_front();
            chk("sync", {29'd0, vs0, hs0, de0}, {29'd0, e.vs, e.hs, e.de});
            chk("rgb", {8'd0, rgb0}, {8'd0, e.rgb});
            chk("gray", {24'd0, gray0}, {24'd0, e.gray});
        end
        if (q1.size() == 3) begin
            e = q1.pop_front();
            chk("clip_sync", {29'd0, vs1, hs1, de1}, {29'd0, e.vs, e.hs, e.de});
            chk("clip_rgb", {8'd0, rgb1}, {8'd0, e.rgb});
            chk("clip_gray", {24'd0, gray1}, {24'd0, e.gray});
        end
        rst_n = rn;
        if (!rn) begin
            foreach (q0[i]) q0[i] = '0;
            foreach (q1[i]) q1[i] = '0;
            mok = 0;
            pvs = 0;
        end
        vs_in = novs ? 1'b0 : early ? ((v == 7 && h >= 16) || v == 8) : (v == 9);
        hs_in = h >= 18 && h < 20;
        de_in = h < HA && v < VA;
        q0.push_back(rn ? model(WXA) : '0);
        q1.push_back(rn ? model(WXB) : '0);
        if (rn) begin
            mok = mok | (vs_in & ~pvs);
            pvs = vs_in;
        end
        h = h == HT - 1 ? 0 : h + 1;
        if (h == 0) v = v == VT - 1 ? 0 : v + 1;
        @(negedge clk);
    endtask

    task automatic frames(input int n);
        repeat (n * HT * VT) step(1);
    endtask

    luma_vec_t lv [9];

    initial begin
        lv[0] = '{24'hFFFFFF, 8'hFF};
        lv[1] = '{24'hFF0000, 8'h4C};
        lv[2] = '{24'h00FF00, 8'h95};
        lv[3] = '{24'h0000FF, 8'h1C};
        lv[4] = '{24'h000000, 8'h00};
        lv[5] = '{24'h040404, 8'h04};
        lv[6] = '{24'h808080, 8'h80};
        lv[7] = '{24'h123456, 8'h2D};
        lv[8] = '{24'h070707, 8'h07};
        foreach (rnd_mem[i]) rnd_mem[i] = 24'($urandom);
        @(negedge clk);
        repeat (3) step(0);
        chk("reset_rgb", {8'd0, rgb0}, 32'd0);
        chk("reset_addr", {24'd0, addr0}, 32'd0);
        chk("reset_gray", {24'd0, gray0}, 32'd0);
        frames(3);
        for (int i = 0; i < 2 * HT * VT && !(h == 8 && v == 3); i++) step(1);
        repeat (2) step(0);
        frames(3);
        repeat ($urandom_range(0, HT * VT - 1)) step(1);
        step(0);
        mode = 3;
        step(0);
        frames(3);
        repeat ($urandom_range(0, HT * VT - 1)) step(1);
        step(0);
        mode = 1;
        step(0);
        frames(2);
        step(0);
        mode = 2;
        step(0);
        frames(2);
        novs = 1;
        mode = 0;
        step(0);
        for (int i = 0; i < HT * VT; i++) begin
            step(1);
            chk("novs_addr", {24'd0, addr0}, 32'd0);
            chk("novs_clip_addr", {24'd0, addr1}, 32'd0);
        end
        novs = 0;
        frames(2);
        early = 1;
        mode = 3;
        step(0);
        frames(3);
        early = 0;
        frames(1);
        for (int i = 0; i < 9; i++) begin
            g_in = lv[i].rgb;
            @(negedge clk);
            chk("luma_table", {24'd0, g_out}, {24'd0, lv[i].gray});
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
